// File: rtl/point_adder_arbiter.sv
// Purpose : two-way round-robin arbiter and sequencer that shares one PointAdder
//           between two requesters; identity operands (point 0) bypass the adder.
// Latency : ack one cycle after the granting IDLE cycle; done at cycle LATENCY+2
//           on the adder path, together with ack (cycle 1) on the bypass path.
// Backpressure: requesters hold req until ack; requests are only sampled in IDLE,
//           so one transaction is in flight at a time and the loser keeps waiting.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req0/req1             per-requester transaction request, held until ack
//   p1_0,p2_0 / p1_1,p2_1 per-requester operands, {y[13:7], x[6:0]}
//   ack0/ack1             one-cycle grant strobe (operands captured)
//   done0/done1           one-cycle completion strobe (sum_out valid)
//   sum_out               last completed result, held until the next completion
//   busy                  high whenever the sequencer is not in IDLE
//   add_p1/add_p2         latched operands presented to the PointAdder
//   add_load              one-cycle start pulse to the PointAdder
//   add_sum               PointAdder result, valid LATENCY cycles after add_load

module point_adder_arbiter #(
  parameter int LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [13:0] p1_0,
  input  logic [13:0] p2_0,
  input  logic [13:0] p1_1,
  input  logic [13:0] p2_1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [13:0] sum_out,
  output logic        busy,
  output logic [13:0] add_p1,
  output logic [13:0] add_p2,
  output logic        add_load,
  input  logic [13:0] add_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter is loaded in LOAD and counts down through WAIT; the capture
  // happens on the WAIT edge where it reads zero, which spaces the capture
  // exactly LATENCY cycles after the add_load cycle.
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t      state;
  logic        prio;      // requester that wins when both ask at once
  logic        gnt;       // requester owning the transaction in flight
  logic [13:0] op1;
  logic [13:0] op2;
  logic [7:0]  cnt;

  // Arbitration and bypass decode for the IDLE cycle.
  logic        grant_vld;
  logic        grant_idx;
  logic [13:0] sel_p1;
  logic [13:0] sel_p2;
  logic        fast_hit;
  logic [13:0] fast_sum;

  always_comb begin
    grant_vld = req0 | req1;
    // With a single request the index is simply whichever one is high.
    grant_idx = (req0 & req1) ? prio : req1;
    sel_p1    = grant_idx ? p1_1 : p1_0;
    sel_p2    = grant_idx ? p2_1 : p2_0;
    // Point 0 is the group identity: P + 0 = P and 0 + Q = Q.
    fast_hit  = (sel_p1 == 14'd0) || (sel_p2 == 14'd0);
    fast_sum  = (sel_p1 == 14'd0) ? sel_p2 : sel_p1;
  end

  // The adder sees the latched operands directly, so they stay stable for the
  // whole transaction and only move on a grant edge.
  assign add_p1 = op1;
  assign add_p2 = op2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      gnt      <= 1'b0;
      op1      <= 14'd0;
      op2      <= 14'd0;
      cnt      <= 8'd0;
      sum_out  <= 14'd0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      add_load <= 1'b0;
    end else begin
      // Strobes are single-cycle by default; states below re-assert them.
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      add_load <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_vld) begin
            op1  <= sel_p1;
            op2  <= sel_p2;
            gnt  <= grant_idx;
            prio <= ~grant_idx;
            ack0 <= ~grant_idx;
            ack1 <= grant_idx;
            busy <= 1'b1;
            if (fast_hit) begin
              // Bypass: result is known now, skip the adder entirely.
              sum_out <= fast_sum;
              done0   <= ~grant_idx;
              done1   <= grant_idx;
              state   <= DONE;
            end else begin
              add_load <= 1'b1;
              state    <= LOAD;
            end
          end
        end

        LOAD: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end

        WAIT: begin
          if (cnt == 8'd0) begin
            sum_out <= add_sum;
            done0   <= ~gnt;
            done1   <= gnt;
            state   <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/point_adder_arbiter.md
# point_adder_arbiter

Sequencing controller and two-way arbiter that shares one `PointAdder` instance (GF(2^7) affine point addition, iterative inverse started by `load`) between two requesters. It grants requesters in round-robin order and latches the operands so they stay stable for the adder's whole latency. It pulses the adder's `load`, waits a fixed number of cycles, captures the sum and returns it with a one-cycle done strobe to the granted requester. Additions with an identity operand (point 0) bypass the adder.

## Interface
- `LATENCY`, default 8: cycles from the `add_load` cycle until `add_sum` is valid. Legal range is 1..255.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req0`, `req1` input 1 each: requester 0 / 1 transaction request, held until its ack.
- `p1_0`, `p2_0` input 14 each: requester 0 operands, format {y[13:7], x[6:0]}.
- `p1_1`, `p2_1` input 14 each: requester 1 operands.
- `ack0`, `ack1` output 1 each: one-cycle grant strobe; operands were captured.
- `done0`, `done1` output 1 each: one-cycle completion strobe; `sum_out` is valid.
- `sum_out` output 14: result of the last completed transaction, held until the next completion.
- `busy` output 1: high in every state except IDLE.
- `add_p1`, `add_p2` output 14 each: latched operands driven to `PointAdder`.
- `add_load` output 1: drives the `PointAdder` `load` input.
- `add_sum` input 14: `PointAdder` `sum`.

## Operation
- **States:** IDLE, LOAD, WAIT, DONE. Reset state is IDLE.
- **Round-robin pointer `prio`:** resets to 0.
- **Arbitration in IDLE:**
  - One request high: grant it.
  - Both high: grant `prio`.
  - Neither high: stay in IDLE.
  - On any grant, `prio` becomes the non-granted index.
- **On grant, at the IDLE exit edge:**
  - latch the granted `p1`/`p2` into `op1`/`op2`;
  - record the granted index in `gnt`;
  - assert `ackN` for the next cycle only.
- **Fast path:** if the granted `p1` == 0, the result is `p2`; else if `p2` == 0, the result is `p1`. Load the result into `sum_out` and go IDLE→DONE. The adder is not loaded.
- **Normal path:** IDLE→LOAD.
  - LOAD: `add_load`=1 for exactly this one cycle; load the counter with LATENCY−1; go to WAIT.
  - WAIT: decrement the counter each cycle. At the edge where the counter is 0, capture `add_sum` into `sum_out` and go to DONE.
- **DONE:** `done[gnt]`=1 for this cycle only, then go to IDLE.
- `add_p1`/`add_p2` = `op1`/`op2` at all times. They change only on a grant edge.
- `sum_out` changes only on entry to DONE.
- Requests arriving outside IDLE are not seen until IDLE. A req dropped before its ack is never granted.
- A requester that holds req high across its done gets a new transaction subject to round-robin. Its operands are re-sampled in IDLE.
- No arithmetic is done in this block. Equal-x and inverse behaviour belong to the adder.

## Timing
- **Reset values:** all outputs 0 (`ack*`, `done*`, `busy`, `add_load`, `sum_out`, `add_p1`, `add_p2`); `op*`=0; counter=0; `prio`=0; `gnt`=0.
- **Normal transaction, cycle 0 = IDLE cycle with req sampled:**
  - cycle 1: `ack`, LOAD, `add_load`;
  - cycles 2..LATENCY+1: WAIT;
  - cycle LATENCY+2: DONE, `done`, valid `sum_out`.
- **Fast path:** cycle 1 carries `ack`, DONE, `done` and `sum_out` together.
- **Back-to-back:** the IDLE cycle after DONE can grant, so the earliest second `ack` is at cycle LATENCY+4 on the normal path and cycle 3 on the fast path.
- **`busy`:** goes high at cycle 1 and drops in the cycle after DONE.
- **Reset mid-operation** (any state):
  - next cycle is IDLE with reset values;
  - the in-flight result is discarded and no `done` is issued;
  - `add_load` is 0;
  - `prio` returns to 0.
- **Simultaneous events:** both requests in the same IDLE cycle follow the `prio` rule. The loser keeps req high and is granted in the next IDLE.

## Test plan
- **Reset:** `reset` high 2 cycles mid-WAIT with LATENCY=8 → next cycle all outputs 0, no `done` ever for the aborted job, `prio`=0.
- **Single normal add:** `req0`, `p1_0`=14'h0123, `p2_0`=14'h0456 → `ack0` at cycle 1, `add_load` at cycle 1 only, `done0` at cycle 10 with `sum_out` equal to the golden `PointAdder` model output.
- **Fast path:** `req1`, `p1_1`=0, `p2_1`=14'h1A2B → `ack1`, `done1` and `sum_out`=14'h1A2B at cycle 1; `add_load` never asserted.
- **Equal x:** `p1`=14'h0085, `p2`=14'h1F05 (both have x=0x05) → normal path; `done` at cycle 10 with `sum_out`=14'h0000.
- **Contention:** `req0` and `req1` held high for four transactions → grant order 0,1,0,1; each `done` goes to the matching requester; gap between normal-path acks is LATENCY+3 cycles.
- **Hold and late request:** `req1` rises during requester 0's WAIT → `ack1` in the cycle after the first IDLE; `sum_out` holds requester 0's result until `done1`.
